// File: rtl/score_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Registered digits, per-digit dark controls with optional leading-zero
// blanking, and a truncation overflow flag.
module score_bcd_converter #(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  lz_blank,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     digit_darkN,
  output logic                  overflow
);

  localparam int unsigned CntW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e              state_q, state_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                blank_q, blank_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [DIGITS-1:0]   dark_q, dark_d;
  logic                ovf_out_q, ovf_out_d;
  logic                done_q, done_d;

  logic [4*DIGITS-1:0] adj;
  logic [DIGITS-1:0]   dark_calc;
  logic                seen_nz;

  // Add-3 adjust of every scratch nibble that is 5 or more.
  always_comb begin
    adj = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Dark controls from the finished scratch: a digit is lit unless blanking
  // is on and it and every higher digit are zero; digit 0 always lit.
  always_comb begin
    dark_calc = '0;
    seen_nz   = 1'b0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      seen_nz = seen_nz | (bcd_q[4*(int'(DIGITS)-1-k) +: 4] != 4'd0);
      dark_calc[int'(DIGITS)-1-k] = ~blank_q | seen_nz;
    end
    dark_calc[0] = 1'b1;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    blank_d   = blank_q;
    digits_d  = digits_q;
    dark_d    = dark_q;
    ovf_out_d = ovf_out_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          bin_d   = bin_in;
          blank_d = lz_blank;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = StShift;
        end
      end
      StShift: begin
        bcd_d = {adj[4*DIGITS-2:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        // A one leaving the top nibble means the value no longer fits.
        if (adj[4*DIGITS-1]) begin
          ovf_d = 1'b1;
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(BIN_W - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        digits_d  = bcd_q;
        dark_d    = dark_calc;
        ovf_out_d = ovf_q;
        done_d    = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= StIdle;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      blank_q   <= 1'b0;
      digits_q  <= '0;
      dark_q    <= DIGITS'(1);
      ovf_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      blank_q   <= blank_d;
      digits_q  <= digits_d;
      dark_q    <= dark_d;
      ovf_out_q <= ovf_out_d;
      done_q    <= done_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign digits      = digits_q;
  assign digit_darkN = dark_q;
  assign overflow    = ovf_out_q;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Scoreboard bench: stimulus pushes expected results from a decimal
// arithmetic model; monitors pop and compare on every done pulse.
module tb_score_bcd_converter;

  typedef struct {
    logic [19:0] dig;
    logic [4:0]  dark;
    logic        ovf;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic resetN = 1'b0;

  logic        start5 = 1'b0, blank5 = 1'b0;
  logic [15:0] bin5 = '0;
  logic        busy5, done5, ovf5;
  logic [19:0] dig5;
  logic [4:0]  dark5;

  logic        start4 = 1'b0, blank4 = 1'b0;
  logic [15:0] bin4 = '0;
  logic        busy4, done4, ovf4;
  logic [15:0] dig4;
  logic [3:0]  dark4;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  exp_t exp5[$];
  exp_t exp4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  score_bcd_converter #(.BIN_W(16), .DIGITS(5)) dut5 (
    .clk(clk), .resetN(resetN), .start(start5), .bin_in(bin5), .lz_blank(blank5),
    .busy(busy5), .done(done5), .digits(dig5), .digit_darkN(dark5), .overflow(ovf5)
  );

  score_bcd_converter #(.BIN_W(16), .DIGITS(4)) dut4 (
    .clk(clk), .resetN(resetN), .start(start4), .bin_in(bin4), .lz_blank(blank4),
    .busy(busy4), .done(done4), .digits(dig4), .digit_darkN(dark4), .overflow(ovf4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Decimal reference: digits of v mod 10^d, overflow if v does not fit,
  // a digit lit unless blanking and nothing nonzero at or above it.
  function automatic exp_t model(input int unsigned v, input bit b, input int unsigned d);
    exp_t e;
    int unsigned p, m, q, pw;
    p = 1;
    for (int unsigned i = 0; i < d; i++) p = p * 10;
    m = v % p;
    e.ovf = (v >= p);
    e.dig = '0;
    e.dark = '0;
    e.acc = 0;
    q = m;
    pw = 1;
    for (int unsigned i = 0; i < d; i++) begin
      e.dig[4*i +: 4] = 4'(q % 10);
      q = q / 10;
      e.dark[i] = !b || (i == 0) || ((m / pw) != 0);
      pw = pw * 10;
    end
    return e;
  endfunction

  // Monitor for the 5-digit instance.
  always @(negedge clk) begin
    if (done5) begin
      if (exp5.size() == 0) begin
        check("dut5_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp5.pop_front();
        check("dut5_digits", 32'(dig5), 32'(e.dig));
        check("dut5_darkN", 32'(dark5), 32'(e.dark));
        check("dut5_overflow", 32'(ovf5), 32'(e.ovf));
        check("dut5_latency", 32'(cyc - e.acc), 32'd17);
        check("dut5_busy_with_done", 32'(busy5), 32'd0);
      end
    end
  end

  // Monitor for the 4-digit instance.
  always @(negedge clk) begin
    if (done4) begin
      if (exp4.size() == 0) begin
        check("dut4_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp4.pop_front();
        check("dut4_digits", 32'(dig4), 32'(e.dig[15:0]));
        check("dut4_darkN", 32'(dark4), 32'(e.dark[3:0]));
        check("dut4_overflow", 32'(ovf4), 32'(e.ovf));
        check("dut4_latency", 32'(cyc - e.acc), 32'd17);
      end
    end
  end

  task automatic issue5(input logic [15:0] v, input bit b, input bit push);
    exp_t e;
    @(negedge clk);
    bin5 = v;
    blank5 = b;
    start5 = 1'b1;
    if (push) begin
      e = model(v, b, 5);
      e.acc = cyc + 1;
      exp5.push_back(e);
    end
    @(negedge clk);
    start5 = 1'b0;
  endtask

  task automatic issue4(input logic [15:0] v, input bit b);
    exp_t e;
    @(negedge clk);
    bin4 = v;
    blank4 = b;
    start4 = 1'b1;
    e = model(v, b, 4);
    e.acc = cyc + 1;
    exp4.push_back(e);
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic wait_done5(input string name);
    int n = 0;
    while (!done5 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done5) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_done4(input string name);
    int n = 0;
    while (!done4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done4) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_reset5(input string name);
    check({name, "_digits"}, 32'(dig5), 32'd0);
    check({name, "_darkN"}, 32'(dark5), 32'b00001);
    check({name, "_overflow"}, 32'(ovf5), 32'd0);
    check({name, "_busy"}, 32'(busy5), 32'd0);
    check({name, "_done"}, 32'(done5), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset5("reset");
    resetN = 1'b1;
    @(negedge clk);

    // Directed values.
    issue5(16'd0, 1'b1, 1'b1);     wait_done5("zero");
    issue5(16'd65535, 1'b1, 1'b1); wait_done5("max");
    issue5(16'd1234, 1'b1, 1'b1);  wait_done5("b1234");
    issue5(16'd1234, 1'b0, 1'b1);  wait_done5("nb1234");

    // Truncation on the narrower instance, then a fitting value.
    issue4(16'd12345, 1'b1); wait_done4("ovf12345");
    issue4(16'd9999, 1'b1);  wait_done4("fit9999");

    // Second start mid-conversion is ignored.
    issue5(16'd1234, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    bin5 = 16'd7;
    start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    wait_done5("restart");
    repeat (25) @(negedge clk);

    // Reset in the middle of a conversion.
    issue5(16'd500, 1'b1, 1'b0);
    repeat (7) @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    check_reset5("midreset");
    @(negedge clk);
    resetN = 1'b1;
    issue5(16'd42, 1'b1, 1'b1); wait_done5("after_reset");

    // Start held high: back-to-back acceptance every 18 clocks.
    begin
      exp_t e;
      int cnt = 0;
      int n = 0;
      @(negedge clk);
      bin5 = 16'd8080;
      blank5 = 1'b1;
      start5 = 1'b1;
      for (int i = 0; i < 3; i++) begin
        e = model(8080, 1'b1, 5);
        e.acc = cyc + 1 + 18 * i;
        exp5.push_back(e);
      end
      while (cnt < 3 && n < 100) begin
        @(negedge clk);
        n++;
        if (done5) cnt++;
      end
      start5 = 1'b0;
      check("backtoback_count", 32'(cnt), 32'd3);
    end

    // Random values on both instances.
    for (int i = 0; i < 30; i++) begin
      logic [15:0] v;
      bit b;
      v = 16'($urandom);
      b = 1'($urandom_range(0, 1));
      if (i % 4 == 0) v = 16'($urandom_range(0, 120));
      issue5(v, b, 1'b1);
      wait_done5("rand5");
      issue4(v, b);
      wait_done4("rand4");
    end

    repeat (25) @(negedge clk);
    check("dut5_queue_empty", 32'(exp5.size()), 32'd0);
    check("dut4_queue_empty", 32'(exp4.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
